// File: rtl/spiflash_reader.sv
// -----------------------------------------------------------------------------
// spiflash_reader
//
// Host-side SPI flash read initiator. Takes one word-read request at a time
// on a valid/ready port and runs a single-I/O, mode-0 READ (0x03)
// transaction on the SPI pins. The transaction is 8 command bits, 24 address
// bits and 32 data bits. The four data bytes are returned as a little-endian
// 32-bit word: the first byte on the wire lands in rsp_data[7:0].
//
// Parameters
//   CLK_DIV  ap_clk cycles per spiclk half-period (>= 1)
//   CSB_GAP  minimum ap_clk cycles with csb high between transactions (>= 1)
//
// Ports
//   ap_clk     in   system clock, rising edge
//   ap_rst     in   synchronous active-high reset
//   req_valid  in   read request
//   req_ready  out  high only when idle and the csb gap has expired
//   req_addr   in   24-bit byte address, sent unmodified
//   rsp_valid  out  one-cycle response pulse, no backpressure
//   rsp_data   out  read word, held until the next response
//   csb        out  flash chip select, active low
//   spiclk     out  SPI clock, idles low
//   io0        out  MOSI
//   io1        in   MISO
// -----------------------------------------------------------------------------
module spiflash_reader #(
    parameter int CLK_DIV = 2,
    parameter int CSB_GAP = 4
) (
    input  logic        ap_clk,
    input  logic        ap_rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [23:0] req_addr,
    output logic        rsp_valid,
    output logic [31:0] rsp_data,
    output logic        csb,
    output logic        spiclk,
    output logic        io0,
    input  logic        io1
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;
    localparam logic [1:0] ST_GAP   = 2'd3;

    localparam logic [7:0]  CMD_READ  = 8'h03;
    localparam logic [15:0] HALF_LAST = 16'(CLK_DIV - 1);
    localparam logic [15:0] GAP_LAST  = 16'(CSB_GAP - 1);

    logic [1:0]  state;
    logic [31:0] tx;
    logic [31:0] rx;
    logic [5:0]  bit_cnt;
    logic [15:0] half_cnt;
    logic [15:0] gap_cnt;

    // rx holds the data bytes in wire order (first byte in [31:24]); the
    // response word wants the first byte in the least significant lane.
    function automatic logic [31:0] wire_to_word(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    // The command/address register shifts in zeros, so io0 naturally drops
    // to 0 for the data phase and stays 0 while idle.
    assign io0 = tx[31];

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state     <= ST_IDLE;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            csb       <= 1'b1;
            spiclk    <= 1'b0;
            tx        <= '0;
            rx        <= '0;
            bit_cnt   <= '0;
            half_cnt  <= '0;
            gap_cnt   <= '0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req_valid && req_ready) begin
                        tx        <= {CMD_READ, req_addr};
                        rx        <= '0;
                        bit_cnt   <= '0;
                        half_cnt  <= '0;
                        spiclk    <= 1'b0;
                        csb       <= 1'b0;
                        req_ready <= 1'b0;
                        state     <= ST_SHIFT;
                    end
                end

                ST_SHIFT: begin
                    if (half_cnt == HALF_LAST) begin
                        half_cnt <= '0;
                        spiclk   <= ~spiclk;
                        if (!spiclk) begin
                            // spiclk 0->1: sample MISO, only the data half matters
                            if (bit_cnt[5]) begin
                                rx <= {rx[30:0], io1};
                            end
                        end else begin
                            // spiclk 1->0: present the next MOSI bit
                            tx      <= {tx[30:0], 1'b0};
                            bit_cnt <= bit_cnt + 6'd1;
                            if (bit_cnt == 6'd63) begin
                                state     <= ST_DONE;
                                csb       <= 1'b1;
                                rsp_valid <= 1'b1;
                                rsp_data  <= wire_to_word(rx);
                                gap_cnt   <= '0;
                            end
                        end
                    end else begin
                        half_cnt <= half_cnt + 16'd1;
                    end
                end

                // The gap is counted from the DONE cycle itself.
                ST_DONE, ST_GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        state     <= ST_IDLE;
                        req_ready <= 1'b1;
                    end else begin
                        gap_cnt <= gap_cnt + 16'd1;
                        state   <= ST_GAP;
                    end
                end

                default: begin
                    state     <= ST_IDLE;
                    req_ready <= 1'b1;
                    csb       <= 1'b1;
                    spiclk    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spiflash_reader.sv
// -----------------------------------------------------------------------------
// tb_spiflash_reader
//
// Directed bench for spiflash_reader. Two instances are built: dut0 with
// CLK_DIV=2 and dut1 with CLK_DIV=1, both with CSB_GAP=4. A behavioural
// flash responder, backed by a small byte image, answers whichever instance
// is selected through a pin mux.
// -----------------------------------------------------------------------------
module tb_spiflash_reader;

    localparam int HALF = 5;

    logic        ap_clk = 1'b0;
    logic        ap_rst = 1'b1;
    logic [23:0] req_addr = '0;
    logic        rv0 = 1'b0, rv1 = 1'b0;
    logic        rdy0, rdy1, rspv0, rspv1;
    logic [31:0] rspd0, rspd1;
    logic        csb0, csb1, sclk0, sclk1, mosi0, mosi1;
    logic        io1 = 1'b0;
    logic        sel = 1'b0;

    logic        csb_m, sclk_m, mosi_m;
    assign csb_m  = sel ? csb1  : csb0;
    assign sclk_m = sel ? sclk1 : sclk0;
    assign mosi_m = sel ? mosi1 : mosi0;

    always #HALF ap_clk = ~ap_clk;

    spiflash_reader #(.CLK_DIV(2), .CSB_GAP(4)) dut0 (
        .ap_clk(ap_clk), .ap_rst(ap_rst), .req_valid(rv0), .req_ready(rdy0),
        .req_addr(req_addr), .rsp_valid(rspv0), .rsp_data(rspd0),
        .csb(csb0), .spiclk(sclk0), .io0(mosi0), .io1(io1));

    spiflash_reader #(.CLK_DIV(1), .CSB_GAP(4)) dut1 (
        .ap_clk(ap_clk), .ap_rst(ap_rst), .req_valid(rv1), .req_ready(rdy1),
        .req_addr(req_addr), .rsp_valid(rspv1), .rsp_data(rspd1),
        .csb(csb1), .spiclk(sclk1), .io0(mosi1), .io1(io1));

    // ---------------- flash responder ----------------
    logic [7:0]  mem [64];
    logic [7:0]  top [4];
    int          rcnt = 0;
    logic [31:0] cmd_cap = '0;
    longint      t_prev = 0;
    longint      last_period = 0;

    function automatic logic [7:0] get_byte(input logic [23:0] a);
        if (a >= 24'hFFFFFC) return top[a[1:0]];
        return mem[a[5:0]];
    endfunction

    always @(negedge csb_m) begin
        rcnt    = 0;
        cmd_cap = '0;
    end

    always @(posedge sclk_m) begin
        if (!csb_m) begin
            if (rcnt < 32) cmd_cap = {cmd_cap[30:0], mosi_m};
            rcnt        = rcnt + 1;
            last_period = $time - t_prev;
            t_prev      = $time;
        end
    end

    always @(negedge sclk_m) begin
        int bp;
        logic [7:0] b;
        logic [23:0] a;
        if (!csb_m && rcnt >= 32 && rcnt < 64) begin
            bp = rcnt - 32;
            a  = cmd_cap[23:0] + 24'(bp / 8);
            b  = get_byte(a);
            io1 = b[7 - (bp % 8)];
        end
    end

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // csb gap / ready monitor for the back-to-back run on dut0
    logic mon_en = 1'b0;
    int   hi_run = 0, min_gap = 1000000, ready_viol = 0;
    bit   seen_low = 1'b0;

    always @(negedge ap_clk) begin
        if (mon_en) begin
            if (!csb0 && rdy0) ready_viol = ready_viol + 1;
            if (csb0) begin
                hi_run = hi_run + 1;
            end else begin
                if (seen_low && hi_run > 0 && hi_run < min_gap) min_gap = hi_run;
                hi_run   = 0;
                seen_low = 1'b1;
            end
        end
    end

    // Handshake on the chosen instance, then wait for its response.
    // lat counts ap_clk edges from the accepting edge (1) to the edge after
    // which rsp_valid is observed high.
    task automatic do_read(input bit which, input logic [23:0] addr,
                           output logic [31:0] data, output int lat);
        int guard;
        @(negedge ap_clk);
        sel      = which;
        req_addr = addr;
        if (which) rv1 = 1'b1; else rv0 = 1'b1;
        guard = 0;
        while (!(which ? rdy1 : rdy0) && guard < 1000) begin
            @(negedge ap_clk);
            guard++;
        end
        if (guard >= 1000) chk("accept_timeout", 32'(guard), 32'd0);
        @(posedge ap_clk);
        #1;
        rv0 = 1'b0;
        rv1 = 1'b0;
        lat = 1;
        while (lat < 5000) begin
            @(posedge ap_clk);
            #1;
            lat++;
            if (which ? rspv1 : rspv0) break;
        end
        data = which ? rspd1 : rspd0;
        if (lat >= 5000) chk("rsp_timeout", 32'(lat), 32'd0);
    endtask

    logic [31:0] d;
    int          lat;
    logic [31:0] resp [3];
    int          got_n;

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 8'h00;
        // word0 = 12345678, little endian
        mem[0] = 8'h78; mem[1] = 8'h56; mem[2] = 8'h34; mem[3] = 8'h12;
        // word1 = CAFEF00D
        mem[4] = 8'h0D; mem[5] = 8'hF0; mem[6] = 8'hFE; mem[7] = 8'hCA;
        // word2 bytes in flash order 11,22,33,44
        mem[8] = 8'h11; mem[9] = 8'h22; mem[10] = 8'h33; mem[11] = 8'h44;
        // word4 = DEADBEEF
        mem[16] = 8'hEF; mem[17] = 8'hBE; mem[18] = 8'hAD; mem[19] = 8'hDE;
        // top word at FFFFFC = A5C30F96
        top[0] = 8'h96; top[1] = 8'h0F; top[2] = 8'hC3; top[3] = 8'hA5;

        // Reset state
        repeat (3) @(posedge ap_clk);
        @(negedge ap_clk);
        ap_rst = 1'b0;
        @(posedge ap_clk);
        #1;
        chk("rst_req_ready", 32'(rdy0), 32'd1);
        chk("rst_rsp_valid", 32'(rspv0), 32'd0);
        chk("rst_rsp_data", rspd0, 32'd0);
        chk("rst_csb", 32'(csb0), 32'd1);
        chk("rst_spiclk", 32'(sclk0), 32'd0);
        chk("rst_io0", 32'(mosi0), 32'd0);

        // Basic read, CLK_DIV=2
        do_read(1'b0, 24'h000000, d, lat);
        chk("t1_cmd", cmd_cap, 32'h03000000);
        chk("t1_latency", 32'(lat), 32'd257);
        chk("t1_data", d, 32'h12345678);
        chk("t1_rises", 32'(rcnt), 32'd64);

        // CLK_DIV=1
        repeat (8) @(posedge ap_clk);
        do_read(1'b1, 24'h000010, d, lat);
        chk("t2_cmd", cmd_cap, 32'h03000010);
        chk("t2_latency", 32'(lat), 32'd129);
        chk("t2_data", d, 32'hDEADBEEF);
        chk("t2_rises", 32'(rcnt), 32'd64);
        chk("t2_spiclk_period", 32'(last_period), 32'(4 * HALF));
        repeat (8) @(posedge ap_clk);

        // Back-to-back with req_valid held, addresses 0,4,8
        @(negedge ap_clk);
        sel = 1'b0;
        hi_run = 0; min_gap = 1000000; ready_viol = 0; seen_low = 1'b0;
        mon_en = 1'b1;
        got_n = 0;
        fork
            begin
                for (int i = 0; i < 3; i++) begin
                    int g;
                    @(negedge ap_clk);
                    req_addr = 24'(4 * i);
                    rv0 = 1'b1;
                    g = 0;
                    while (!rdy0 && g < 1000) begin
                        @(negedge ap_clk);
                        g++;
                    end
                    @(posedge ap_clk);
                end
                #1;
                rv0 = 1'b0;
            end
            begin
                int cyc;
                cyc = 0;
                while (got_n < 3 && cyc < 3000) begin
                    @(posedge ap_clk);
                    #1;
                    cyc++;
                    if (rspv0) begin
                        resp[got_n] = rspd0;
                        got_n++;
                    end
                end
            end
        join
        mon_en = 1'b0;
        chk("b2b_count", 32'(got_n), 32'd3);
        chk("b2b_data0", resp[0], 32'h12345678);
        chk("b2b_data1", resp[1], 32'hCAFEF00D);
        chk("b2b_data2", resp[2], 32'h44332211);
        chk("b2b_gap_ok", 32'(min_gap >= 4 && min_gap < 1000000), 32'd1);
        chk("b2b_ready_low", 32'(ready_viol), 32'd0);
        repeat (8) @(posedge ap_clk);

        // Reset mid-transaction at bit 40
        begin
            int g;
            @(negedge ap_clk);
            sel = 1'b0;
            req_addr = 24'h000008;
            rv0 = 1'b1;
            g = 0;
            while (!rdy0 && g < 1000) begin
                @(negedge ap_clk);
                g++;
            end
            @(posedge ap_clk);
            #1;
            rv0 = 1'b0;
            g = 0;
            while (rcnt < 40 && g < 2000) begin
                @(negedge ap_clk);
                g++;
            end
            chk("abort_reached_bit40", 32'(rcnt), 32'd40);
            ap_rst = 1'b1;
            @(posedge ap_clk);
            #1;
            chk("abort_csb", 32'(csb0), 32'd1);
            chk("abort_spiclk", 32'(sclk0), 32'd0);
            chk("abort_io0", 32'(mosi0), 32'd0);
            chk("abort_rsp_valid", 32'(rspv0), 32'd0);
            chk("abort_req_ready", 32'(rdy0), 32'd1);
            @(negedge ap_clk);
            ap_rst = 1'b0;
            g = 0;
            for (int i = 0; i < 300; i++) begin
                @(posedge ap_clk);
                #1;
                if (rspv0) g++;
            end
            chk("abort_no_rsp", 32'(g), 32'd0);
        end
        do_read(1'b0, 24'h000004, d, lat);
        chk("after_abort_data", d, 32'hCAFEF00D);
        repeat (8) @(posedge ap_clk);

        // Top-of-address read, no wrap/increment inside the reader
        do_read(1'b0, 24'hFFFFFC, d, lat);
        chk("top_cmd", cmd_cap, 32'h03FFFFFC);
        chk("top_data", d, 32'hA5C30F96);
        repeat (8) @(posedge ap_clk);

        // Byte order on the faster instance
        do_read(1'b1, 24'h000008, d, lat);
        chk("byte_order", d, 32'h44332211);

        repeat (4) @(posedge ap_clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
